// File: rtl/sysbus_arbiter_if.sv
// Shared-bus port bundle: client-side (cli_*) and Sysbus-side (bus_*) handshake signals.
// The arbiter uses the master view; caches and the Sysbus model use the slave view.
interface sysbus_arbiter_if #(
  parameter int W = 64,
  parameter int T = 13
);
  logic [1:0]     cli_bid;
  logic [1:0]     cli_grant;
  logic [1:0]     cli_reqcyc;
  logic [2*W-1:0] cli_req;
  logic [2*T-1:0] cli_reqtag;
  logic [1:0]     cli_reqack;
  logic [1:0]     cli_respcyc;
  logic [W-1:0]   cli_resp;
  logic [T-1:0]   cli_resptag;
  logic [1:0]     cli_respack;

  logic           bus_reqcyc;
  logic [W-1:0]   bus_req;
  logic [T-1:0]   bus_reqtag;
  logic           bus_reqack;
  logic           bus_respcyc;
  logic [W-1:0]   bus_resp;
  logic [T-1:0]   bus_resptag;
  logic           bus_respack;

  modport master (
    input  cli_bid, cli_reqcyc, cli_req, cli_reqtag, cli_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output cli_grant, cli_reqack, cli_respcyc, cli_resp, cli_resptag,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport slave (
    output cli_bid, cli_reqcyc, cli_req, cli_reqtag, cli_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  cli_grant, cli_reqack, cli_respcyc, cli_resp, cli_resptag,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/sysbus_arbiter.sv
// Round-robin owner of the single Sysbus port for icache (0) / dcache (1); grant is registered (1 cycle),
// request/response beats pass combinationally; stalls come from bus_reqack / respack handshakes.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input logic              clk,
  input logic              reset,
  sysbus_arbiter_if.master sb
);
  localparam int W  = BUS_DATA_WIDTH;
  localparam int T  = BUS_TAG_WIDTH;
  localparam int CW = $clog2(LINE_BEATS + 2);
  localparam logic [CW-1:0] WR_BEATS   = CW'(LINE_BEATS + 1);
  localparam logic [CW-1:0] RESP_BEATS = CW'(LINE_BEATS);

  typedef enum logic [1:0] {IDLE, GRANT, REQ, RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          is_wr_q, is_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  logic          own_bid, own_reqcyc, own_respack, wr_now;
  logic [W-1:0]  own_req;
  logic [T-1:0]  own_tag;
  logic [1:0]    own_oh;

  assign own_bid     = sb.cli_bid[owner_q];
  assign own_reqcyc  = sb.cli_reqcyc[owner_q];
  assign own_respack = sb.cli_respack[owner_q];
  assign own_req     = owner_q ? sb.cli_req[2*W-1:W]    : sb.cli_req[W-1:0];
  assign own_tag     = owner_q ? sb.cli_reqtag[2*T-1:T] : sb.cli_reqtag[T-1:0];
  assign own_oh      = {owner_q, ~owner_q};
  assign cnt_inc     = cnt_q + CW'(1);
  // Transaction type is taken from the first (address) beat; later beats reuse the captured flag.
  assign wr_now      = (cnt_q == '0) ? own_tag[T-1] : is_wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    is_wr_d        = is_wr_q;
    cnt_d          = cnt_q;
    sb.cli_grant   = 2'b00;
    sb.cli_reqack  = 2'b00;
    sb.cli_respcyc = 2'b00;
    sb.cli_resp    = '0;
    sb.cli_resptag = '0;
    sb.bus_reqcyc  = 1'b0;
    sb.bus_req     = '0;
    sb.bus_reqtag  = '0;
    sb.bus_respack = 1'b0;

    if (state_q != IDLE) begin
      sb.cli_grant   = own_oh;
      sb.cli_resp    = sb.bus_resp;
      sb.cli_resptag = sb.bus_resptag;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|sb.cli_bid) begin
          owner_d = (&sb.cli_bid) ? ~last_q : sb.cli_bid[1];
          state_d = GRANT;
        end
      end

      GRANT, REQ: begin
        sb.bus_reqcyc = own_reqcyc;
        sb.bus_req    = own_req;
        sb.bus_reqtag = own_tag;
        sb.cli_reqack = own_oh & {2{sb.bus_reqack}};
        if (own_reqcyc) begin
          if (cnt_q == '0) begin
            is_wr_d = own_tag[T-1];
          end
          if (state_q == GRANT) begin
            state_d = REQ;
          end
          if (sb.bus_reqack) begin
            if (wr_now && cnt_inc == WR_BEATS) begin
              cnt_d   = '0;
              last_d  = owner_q;
              state_d = IDLE;
            end else if (!wr_now) begin
              cnt_d   = '0;
              state_d = RESP;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end else if (state_q == GRANT && !own_bid) begin
          // Abandoned grant: round-robin history is left untouched.
          state_d = IDLE;
        end
      end

      RESP: begin
        sb.cli_respcyc = own_oh & {2{sb.bus_respcyc}};
        sb.bus_respack = own_respack;
        if (sb.bus_respcyc && own_respack) begin
          if (cnt_inc == RESP_BEATS) begin
            cnt_d   = '0;
            last_d  = owner_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Randomised bench: drivers model both caches and the Sysbus; a monitor pops expected grants,
// request beats and response beats from scoreboard queues filled by a round-robin reference model.
module tb_sysbus_arbiter;
  localparam int W  = 64;
  localparam int T  = 13;
  localparam int LB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sysbus_arbiter_if #(.W(W), .T(T)) sb();

  sysbus_arbiter #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T), .LINE_BEATS(LB)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb.master)
  );

  typedef struct {
    int           cl;
    logic [W-1:0] dat;
    logic [T-1:0] tag;
  } beat_t;

  beat_t req_q[$];
  beat_t rsp_q[$];
  int    grant_q[$];

  int errors = 0;
  int checks = 0;

  bit         req_window  = 1'b0;
  bit         resp_window = 1'b0;
  bit         force_stall = 1'b0;
  int         cur_owner   = 0;
  int         drv_client  = -1;
  int         m_last      = 1;
  logic [1:0] active_mask = 2'b00;

  function automatic logic [1:0] oh(input int c);
    return (c != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT beat with no expected entry", name);
  endtask

  // Advance one cycle; afterwards scramble every input the current transaction does not own.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i != drv_client) begin
        sb.cli_req[i*W +: W]    = {$urandom, $urandom};
        sb.cli_reqtag[i*T +: T] = T'($urandom);
      end
      if (!active_mask[i]) sb.cli_reqcyc[i] = 1'($urandom);
      if (!resp_window)    sb.cli_respack[i] = 1'($urandom);
    end
    if (!resp_window) begin
      sb.bus_respcyc = 1'($urandom);
      sb.bus_resp    = {$urandom, $urandom};
      sb.bus_resptag = T'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tagname);
    chk({tagname, "_grant"},   sb.cli_grant,   2'b00);
    chk({tagname, "_reqack"},  sb.cli_reqack,  2'b00);
    chk({tagname, "_respcyc"}, sb.cli_respcyc, 2'b00);
    chk({tagname, "_resp"},    sb.cli_resp,    '0);
    chk({tagname, "_resptag"}, sb.cli_resptag, '0);
    chk({tagname, "_breqcyc"}, sb.bus_reqcyc,  1'b0);
    chk({tagname, "_breq"},    sb.bus_req,     '0);
    chk({tagname, "_breqtag"}, sb.bus_reqtag,  '0);
    chk({tagname, "_brespack"},sb.bus_respack, 1'b0);
  endtask

  // One complete transaction for client c; the DUT should grant it on the next edge.
  task automatic do_txn(input int c, input bit wr, input int abort_at);
    logic [T-1:0] tag;
    logic [W-1:0] d;
    beat_t        e;
    int           nbeats, tries;
    bit           ack, v, a;
    drv_client = c;
    sb.cli_reqcyc[c] = 1'b0;
    tick();
    chk("grant_latency", sb.cli_grant, oh(c));
    for (int k = 0; k < 20 && sb.cli_grant != oh(c); k++) tick();
    cur_owner = c;
    repeat ($urandom_range(0, 2)) tick();

    tag = T'($urandom);
    tag[T-1] = wr;
    sb.cli_reqtag[c*T +: T] = tag;
    nbeats = wr ? LB + 1 : 1;
    req_window = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom};
      sb.cli_req[c*W +: W] = d;
      sb.cli_reqcyc[c] = 1'b1;
      e.cl = c; e.dat = d; e.tag = tag;
      req_q.push_back(e);
      tries = 0;
      do begin
        if (force_stall && b == 0 && tries < 3) ack = 1'b0;
        else if (tries >= 4)                   ack = 1'b1;
        else                                   ack = ($urandom_range(0, 3) != 0);
        sb.bus_reqack = ack;
        tick();
        tries++;
      end while (!ack);
      if (b == 0) sb.cli_bid[c] = 1'b0;
    end
    sb.cli_reqcyc[c] = 1'b0;
    sb.bus_reqack = 1'b0;
    req_window = 1'b0;

    if (!wr) begin
      resp_window = 1'b1;
      for (int b = 0; b < LB; b++) begin
        if (b == abort_at) begin
          sb.bus_respcyc = 1'b0;
          sb.cli_respack = 2'b00;
          reset = 1'b1;
          rsp_q.delete();
          resp_window = 1'b0;
          tick();
          sb.bus_respcyc = 1'b1;
          sb.cli_respack = 2'b11;
          sb.cli_reqcyc  = 2'b11;
          sb.bus_reqack  = 1'b1;
          #1;
          check_all_zero("rst_mid");
          sb.cli_reqcyc = 2'b00;
          sb.bus_reqack = 1'b0;
          active_mask = 2'b00;
          drv_client = -1;
          m_last = 1;
          return;
        end
        d = {$urandom, $urandom};
        sb.bus_resp = d;
        sb.bus_resptag = tag;
        e.cl = c; e.dat = d; e.tag = tag;
        rsp_q.push_back(e);
        tries = 0;
        do begin
          v = (tries >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
          a = (tries >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
          sb.bus_respcyc = v;
          sb.cli_respack[c] = a;
          tick();
          tries++;
        end while (!(v && a));
      end
      sb.bus_respcyc = 1'b0;
      sb.cli_respack[c] = 1'b0;
      resp_window = 1'b0;
    end
    m_last = c;
    active_mask[c] = 1'b0;
    drv_client = -1;
  endtask

  // Reference model: lone bidder wins; on a tie the client not served most recently wins.
  task automatic round(input logic [1:0] pat, input bit wr0, input bit wr1);
    int first;
    active_mask = pat;
    for (int i = 0; i < 2; i++) if (pat[i]) sb.cli_reqcyc[i] = 1'b0;
    sb.cli_bid = pat;
    first = (pat == 2'b11) ? 1 - m_last : (pat[1] ? 1 : 0);
    grant_q.push_back(first);
    if (pat == 2'b11) grant_q.push_back(1 - first);
    do_txn(first, (first != 0) ? wr1 : wr0, -1);
    if (pat == 2'b11) do_txn(1 - first, (first != 0) ? wr0 : wr1, -1);
  endtask

  task automatic abandon(input int c);
    active_mask = oh(c);
    sb.cli_reqcyc[c] = 1'b0;
    sb.cli_bid = oh(c);
    grant_q.push_back(c);
    tick();
    chk("abandon_grant", sb.cli_grant, oh(c));
    sb.cli_bid = 2'b00;
    tick();
    chk("abandon_idle", sb.cli_grant, 2'b00);
    active_mask = 2'b00;
  endtask

  logic [1:0] g_prev = 2'b00;
  beat_t      me;

  always @(negedge clk) begin
    if (!reset) begin
      if (sb.cli_grant != g_prev && sb.cli_grant != 2'b00) begin
        if (grant_q.size() == 0) miss("grant");
        else chk("grant_owner", sb.cli_grant, oh(grant_q.pop_front()));
      end
      if (sb.bus_reqcyc && sb.bus_reqack) begin
        if (req_q.size() == 0) miss("req_beat");
        else begin
          me = req_q.pop_front();
          chk("req_dat", sb.bus_req, me.dat);
          chk("req_tag", sb.bus_reqtag, me.tag);
          chk("reqack_route", sb.cli_reqack, oh(me.cl));
        end
      end
      if (sb.bus_respcyc && sb.bus_respack) begin
        if (rsp_q.size() == 0) miss("resp_beat");
        else begin
          me = rsp_q.pop_front();
          chk("respcyc_route", sb.cli_respcyc, oh(me.cl));
          chk("resp_dat", sb.cli_resp, me.dat);
          chk("resp_tag", sb.cli_resptag, me.tag);
        end
      end
      if (req_window)  chk("req_hold", sb.bus_reqcyc, 1'b1);
      else             chk("no_reqcyc", sb.bus_reqcyc, 1'b0);
      if (!resp_window) begin
        chk("no_respcyc", sb.cli_respcyc, 2'b00);
        chk("no_respack", sb.bus_respack, 1'b0);
      end
      if (req_window || resp_window) chk("grant_hold", sb.cli_grant, oh(cur_owner));
    end
    g_prev = sb.cli_grant;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sb.cli_bid = 2'b11;
    sb.cli_reqcyc = 2'b00;
    sb.cli_req = '0;
    sb.cli_reqtag = '0;
    sb.cli_respack = 2'b00;
    sb.bus_reqack = 1'b0;
    sb.bus_respcyc = 1'b0;
    sb.bus_resp = '0;
    sb.bus_resptag = '0;
    repeat (3) tick();
    check_all_zero("reset");
    sb.cli_bid = 2'b00;
    reset = 1'b0;
    tick();

    round(2'b11, 1'b0, 1'b0);
    round(2'b01, 1'b0, 1'b0);
    round(2'b10, 1'b1, 1'b1);
    force_stall = 1'b1;
    round(2'b01, 1'b0, 1'b0);
    force_stall = 1'b0;
    abandon(1);
    round(2'b11, 1'b1, 1'b0);

    active_mask = 2'b01;
    sb.cli_reqcyc[0] = 1'b0;
    sb.cli_bid = 2'b01;
    grant_q.push_back(0);
    do_txn(0, 1'b0, 4);
    reset = 1'b0;
    active_mask = 2'b10;
    sb.cli_reqcyc[1] = 1'b0;
    sb.cli_bid = 2'b10;
    grant_q.push_back(1);
    do_txn(1, 1'b0, -1);

    for (int r = 0; r < 25; r++) begin
      round(2'($urandom_range(1, 3)), 1'($urandom), 1'($urandom));
    end

    repeat (3) tick();
    chk("grant_q_empty", grant_q.size(), 0);
    chk("req_q_empty",   req_q.size(),   0);
    chk("rsp_q_empty",   rsp_q.size(),   0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
